// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared constants and ack FSM state type for the receive FIFO.
package rx_fifo_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic {ACK_IDLE = 1'b0, ACK_PULSE = 1'b1} ack_state_e;
endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: 2^DEPTH_LOG2 x byte register array, synchronous write, asynchronous read.
module rx_fifo_mem
   import rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [BYTE_W-1:0]     wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [BYTE_W-1:0]     rdata
);
   logic [BYTE_W-1:0] mem_q [1<<DEPTH_LOG2];
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: acknowledges receiver bytes and buffers them in a show-ahead FIFO
// with occupancy, sticky overrun and a threshold interrupt.
module rx_fifo
   import rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_done,
   input  logic [7:0]            rx_byte,
   output logic                  rx_read,
   input  logic                  rd_pop,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  clear,
   input  logic [DEPTH_LOG2:0]   thresh,
   output logic                  irq
);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
   ack_state_e              state_q, state_d;
   logic                    rx_read_q, rx_read_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    overrun_q, overrun_d;
   logic                    irq_q, irq_d;
   logic                    capture, full, empty, do_push, do_pop;
   logic [BYTE_W-1:0]       mem_rdata;
   // clear wins over both push and pop; the ack FSM runs regardless of it
   always_comb begin
      capture   = (state_q == ACK_IDLE) && rx_done;
      full      = count_q == FULL_CNT;
      empty     = count_q == '0;
      do_pop    = rd_pop && !empty && !clear;
      do_push   = capture && (!full || rd_pop) && !clear;
      state_d   = capture ? ACK_PULSE : ACK_IDLE;
      rx_read_d = capture;
      wr_ptr_d  = clear ? '0 : do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d  = clear ? '0 : do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d   = clear ? '0 :
                  (do_push && !do_pop) ? count_q + CNT_ONE :
                  (do_pop && !do_push) ? count_q - CNT_ONE : count_q;
      overrun_d = !clear && (overrun_q || (capture && full && !rd_pop));
      irq_d     = ((count_d >= thresh) && (thresh != '0)) || overrun_d;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACK_IDLE;
         rx_read_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_read_q <= rx_read_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         irq_q     <= irq_d;
      end
   end
   rx_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr_q),
      .wdata (rx_byte),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );
   assign rx_read  = rx_read_q;
   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem_rdata;
   assign count    = count_q;
   assign overrun  = overrun_q;
   assign irq      = irq_q;
endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Downstream consumer of the 8N1 serial receiver.
- Takes rx_done/rx_byte and acknowledges each byte with a one-cycle rx_read pulse.
- Buffers received bytes in a show-ahead FIFO for the peripheral register bus.
- Provides occupancy, sticky overrun and a threshold interrupt, so software need not service every byte at line rate.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 bytes); legal range 1..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_done  in  1  receiver byte-ready flag; level, held until acknowledged
- rx_byte  in  8  receiver data; valid while rx_done=1
- rx_read  out  1  registered one-cycle acknowledge to the receiver
- rd_pop  in  1  bus pops the head entry this cycle
- rd_data  out  8  head entry (show-ahead); 0 when empty
- rd_valid  out  1  FIFO non-empty
- count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
- overrun  out  1  sticky: a byte arrived while the FIFO was full
- clear  in  1  flush FIFO and clear overrun
- thresh  in  DEPTH_LOG2+1  interrupt level
- irq  out  1  (count >= thresh && thresh != 0) || overrun

Behaviour:
- Reset (rst_n=0 at posedge): FIFO pointers=0, count=0, rd_valid=0, rd_data=0, rx_read=0, overrun=0, irq=0, ack FSM=IDLE. Memory contents are don't-care.
- Ack FSM, two states:
  - IDLE: if rx_done=1, capture rx_byte (push request) -> ACK; rx_read<=1.
  - ACK: rx_done is ignored (the receiver clears it one cycle after seeing rx_read); rx_read<=0 -> IDLE.
  - rx_read is high for exactly one cycle per byte, in the cycle after capture.
  - Minimum spacing of 2 cycles between captures is guaranteed by the UART frame time.
- Push in IDLE with rx_done=1:
  - If not full, or full with rd_pop=1 in the same cycle: write at wr_ptr and increment it (wraps modulo depth).
  - If full and rd_pop=0: byte is dropped, overrun<=1, pointers unchanged. The receiver is still acknowledged.
- Pop: rd_pop=1 with rd_valid=1 increments rd_ptr (wraps). rd_pop while empty is ignored, with no state change.
- Simultaneous push and pop:
  - count unchanged.
  - When empty, a push with rd_pop=1 pushes only; the pop is ignored.
- count: +1 on push-only, -1 on pop-only. Width DEPTH_LOG2+1, so full = 2^DEPTH_LOG2 is representable.
- rd_data/rd_valid:
  - Combinational from memory at rd_ptr and count != 0.
  - A pushed byte is visible the cycle after the push edge.
  - After a pop, the next entry is visible the cycle after.
- clear=1:
  - Pointers and count go to 0 and overrun goes to 0 next cycle.
  - Overrides push and pop that cycle; a byte captured that cycle is discarded, but rx_read is still issued.
  - The ack FSM is not reset.
- overrun clears only on clear or reset.
- irq is registered, updated every cycle from next-state count/overrun. thresh=0 disables the level term.
- Reset mid-ack: rx_read drops immediately. The receiver keeps rx_done=1, so the byte is re-captured after reset. This is the intended behaviour.

Decomposition:
- Shared package:
  - Ack FSM state localparams ACK_IDLE=0, ACK_PULSE=1.
  - Byte width constant 8.
- One sub-module: rx_fifo_mem.
  - Simple dual-port 2^DEPTH_LOG2 x 8 register array.
  - Synchronous write, asynchronous read.
  - No reset on storage.
- Pointers, count, flags and FSM live in rx_fifo.

Test Plan:
- Single byte: rx_done=1 with rx_byte=0xA5, rx_done dropping 1 cycle after rx_read -> rx_read pulses once at capture+1; rd_valid=1 and rd_data=0xA5 at capture+1; count=1; rd_pop -> rd_valid=0, count=0.
- Ordering/wrap (DEPTH_LOG2=2): push 0x01..0x03, pop 2, push 0x04..0x06 -> pops yield 0x03,0x04,0x05,0x06 in order; count returns to 0; pointers wrap without error.
- Overrun: fill 4 entries, push 0x77 with no pop -> rx_read still pulses; count stays 4; overrun=1; irq=1; 0x77 never appears. clear -> count=0, overrun=0, irq=0.
- Full with simultaneous pop: full FIFO, push 0x55 in the same cycle as rd_pop -> count stays 4; overrun=0; 0x55 is the last entry popped.
- Threshold: thresh=3 -> irq=0 at count 2, irq=1 the cycle after the third push, irq=0 after one pop. thresh=0 -> irq=0 at any count without overrun.
- Reset and empty pop: rst_n=0 during ACK -> rx_read=0 next cycle; rx_done still high after reset -> byte is re-captured once. rd_pop when empty -> count stays 0, rd_data=0.
